// File: rtl/tdm_demux_pkg.sv
//----------------------------------------------------------------------------
// Module   : tdm_demux_pkg
// Brief    : Shared types and constants for the two-channel TDM demultiplexer.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package tdm_demux_pkg;

  localparam int c_default_width = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_shreg.sv
//----------------------------------------------------------------------------
// Module   : demux_shreg
// Brief    : LSB-first shift register with shift-enable and clear; exposes its
//            next-state value so a caller can capture a word on the same edge
//            that shifts in its final bit.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module demux_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_q_next
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  // Clear together with enable restarts the word with i_din as its first bit.
  always_comb begin
    w_q_next = r_q;
    if (i_clr && i_en) begin
      w_q_next = {i_din, {(WIDTH-1){1'b0}}};
    end else if (i_clr) begin
      w_q_next = '0;
    end else if (i_en) begin
      w_q_next = {i_din, r_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign o_q_next = w_q_next;

endmodule

`default_nettype wire

// File: rtl/tdm_demux2.sv
//----------------------------------------------------------------------------
// Module   : tdm_demux2
// Brief    : Splits a framed serial TDM stream into two interleaved channel
//            words, with frame lock and mid-frame sync error reporting.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tdm_demux2
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             valid,
  output logic             locked,
  output logic             frame_err
);

  localparam int                 c_cnt_w = $clog2(2 * WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(2 * WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]   r_out0;
  logic [WIDTH-1:0]   r_out1;
  logic               r_valid;
  logic               r_frame_err;
  logic [1:0]         w_sh_en;
  logic               w_sh_clr;
  logic               w_load;
  logic               w_err;
  logic [WIDTH-1:0]   w_q_next [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      demux_shreg #(
        .WIDTH (WIDTH)
      ) u_shreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (w_sh_clr),
        .i_en     (w_sh_en[gi]),
        .i_din    (din),
        .o_q_next (w_q_next[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_en     = 2'b00;
    w_sh_clr    = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sync) begin
          w_sh_clr    = 1'b1;
          w_sh_en[0]  = 1'b1;
          w_cnt_nxt   = c_cnt_w'(1);
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sync) begin
          // Any sync restarts the frame; only a mid-frame one is an error.
          w_sh_clr   = 1'b1;
          w_sh_en[0] = 1'b1;
          w_cnt_nxt  = c_cnt_w'(1);
          w_err      = (r_cnt != '0);
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_sh_en[r_cnt[0]] = 1'b1;
          if (r_cnt == c_last) begin
            w_cnt_nxt = '0;
            w_load    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Words are taken from the shift registers' next value so the final bit is included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out0      <= '0;
      r_out1      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_valid     <= w_load;
      r_frame_err <= w_err;
      if (w_load) begin
        r_out0 <= w_q_next[0];
        r_out1 <= w_q_next[1];
      end
    end
  end

  assign out0      = r_out0;
  assign out1      = r_out1;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign locked    = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux2.sv
//----------------------------------------------------------------------------
// Module   : tb_tdm_demux2
// Brief    : Directed self-checking bench for tdm_demux2 at WIDTH = 8.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux2;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             din;
  logic             sync;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic             valid;
  logic             locked;
  logic             frame_err;

  int               n_tests;
  int               n_fail;
  logic [WIDTH-1:0] exp_out0;
  logic [WIDTH-1:0] exp_out1;

  tdm_demux2 #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .sync      (sync),
    .out0      (out0),
    .out1      (out1),
    .valid     (valid),
    .locked    (locked),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one bit, clock it in, then sample just after the edge.
  task automatic step(input logic s, input logic d);
    sync = s;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out0"}, 32'(out0), 32'h0);
    check({tag, "_out1"}, 32'(out1), 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_locked"}, 32'(locked), 32'h0);
    check({tag, "_ferr"}, 32'(frame_err), 32'h0);
  endtask

  // Full frame: bit k -> channel k%2, position k/2, sync on bit 0.
  task automatic send_frame(input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] c1,
                            input logic exp_err);
    for (int k = 0; k < 2 * WIDTH; k++) begin
      step(k == 0, (k % 2 == 1) ? c1[k/2] : c0[k/2]);
      check("frm_locked", 32'(locked), 32'h1);
      check("frm_ferr", 32'(frame_err), (k == 0) ? 32'(exp_err) : 32'h0);
      if (k < 2 * WIDTH - 1) begin
        check("frm_valid_low", 32'(valid), 32'h0);
        check("frm_hold0", 32'(out0), 32'(exp_out0));
        check("frm_hold1", 32'(out1), 32'(exp_out1));
      end
    end
    exp_out0 = c0;
    exp_out1 = c1;
    check("frm_valid", 32'(valid), 32'h1);
    check("frm_out0", 32'(out0), 32'(c0));
    check("frm_out1", 32'(out1), 32'(c1));
  endtask

  initial begin
    logic [WIDTH-1:0] part0;
    logic [WIDTH-1:0] part1;
    n_tests  = 0;
    n_fail   = 0;
    exp_out0 = '0;
    exp_out1 = '0;
    reset_n  = 1'b0;
    din      = 1'b0;
    sync     = 1'b0;

    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b0, 1'b1);
    check_reset_outputs("idle");

    // Single frame.
    send_frame(8'hA5, 8'h3C, 1'b0);

    // Back-to-back frames; valid must drop on the first bit of the next frame.
    send_frame(8'h01, 8'h80, 1'b0);
    send_frame(8'hFF, 8'h00, 1'b0);

    // No sync after a completed frame: drop lock, ignore din.
    step(1'b0, 1'b1);
    check("unlock_locked", 32'(locked), 32'h0);
    check("unlock_valid", 32'(valid), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i[0]);
      check("idle_locked", 32'(locked), 32'h0);
      check("idle_valid", 32'(valid), 32'h0);
      check("idle_ferr", 32'(frame_err), 32'h0);
      check("idle_out0", 32'(out0), 32'hFF);
      check("idle_out1", 32'(out1), 32'h00);
    end

    // Abort after bits 0..6, sync again on bit 7.
    part0 = 8'h12;
    part1 = 8'h34;
    for (int k = 0; k < 7; k++) begin
      step(k == 0, (k % 2 == 1) ? part1[k/2] : part0[k/2]);
      check("part_valid", 32'(valid), 32'h0);
      check("part_ferr", 32'(frame_err), 32'h0);
    end
    send_frame(8'h5A, 8'hC3, 1'b1);

    // Asynchronous reset at bit 9, between clock edges.
    part0 = 8'h77;
    part1 = 8'h11;
    for (int k = 0; k < 9; k++) begin
      step(k == 0, (k % 2 == 1) ? part1[k/2] : part0[k/2]);
    end
    sync = 1'b0;
    din  = part1[4];
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    reset_n  = 1'b1;
    exp_out0 = '0;
    exp_out1 = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check("post_rst_locked", 32'(locked), 32'h0);
    end
    send_frame(8'h6B, 8'hD2, 1'b0);

    // Random din with no sync from reset.
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst2");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'($urandom_range(1, 0)));
      check("rnd_locked", 32'(locked), 32'h0);
      check("rnd_valid", 32'(valid), 32'h0);
      check("rnd_ferr", 32'(frame_err), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
